ef_uart_tx_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that lets NUM_REQ byte-stream requesters share one EF_UART transmit FIFO write port.
- Sits between on-chip producers (CPU shim, DMA, debug streamer) and the UART TX FIFO write interface.
- Holds a grant for a whole packet, so bytes from different requesters never interleave on the serial line.
- A stalled packet is released after a timeout so one requester cannot hang the UART.

---
 rtl/ef_uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ef_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_uart_tx_arbiter.sv
// ef_uart_tx_arbiter
//   Round-robin, packet-locked arbiter that lets NUM_REQ byte-stream
//   requesters share one EF_UART TX FIFO write port. A grant is held for a
//   whole packet (until req_last is accepted) or until the owner has been
//   starved for TIMEOUT consecutive cycles.
//   Optional build macro: EF_UART_TX_ARB_PRIO_EN makes requester 0 high
//   priority in IDLE (it never preempts a packet in progress).
module ef_uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr,
  output logic [DW-1:0]              fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam int unsigned   GW         = $clog2(NUM_REQ);
  localparam int unsigned   CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] STARVE_MAX = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_IDX   = GW'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;

  state_e        state_q,  state_d;
  logic [GW-1:0] grant_q,  grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] starve_q, starve_d;

  logic          cur_valid;
  logic          cur_last;
  logic [DW-1:0] cur_data;
  logic          xfer_go;
  logic          starved;
  logic          expire;
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] ptr_after;
  int unsigned   cand;

  // State register: FSM state, owner, round-robin pointer, starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
    end
  end

  // Owner's stream selected by the registered grant, plus per-cycle XFER events
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[i*DW +: DW];
      end
    end
    xfer_go = (state_q == S_XFER) && cur_valid && !fifo_full;
    starved = (state_q == S_XFER) && !cur_valid;
    expire  = starved && (starve_q == STARVE_MAX);
  end

  // Arbitration policy: first valid index scanning upward from rr_ptr, and the
  // pointer value to adopt when the current owner releases
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned o = 0; o < NUM_REQ; o++) begin
      cand = 32'(rr_ptr_q) + o;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!win_found && (cand == j) && req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = GW'(j);
        end
      end
    end
    ptr_after = (grant_q == LAST_IDX) ? '0 : grant_q + GW'(1);
`ifdef EF_UART_TX_ARB_PRIO_EN
    // Requester 0 bypasses the rotation and leaves the pointer where it was
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
    if (grant_q == '0) ptr_after = rr_ptr_q;
`endif
  end

  // Next-state: arbitrate in IDLE, hold the grant through the packet in XFER
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && win_found) begin
          grant_d  = win_idx;
          starve_d = '0;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        if (xfer_go) begin
          starve_d = '0;
          if (cur_last) begin
            state_d  = S_IDLE;
            rr_ptr_d = ptr_after;
          end
        end else if (expire) begin
          state_d  = S_IDLE;
          rr_ptr_d = ptr_after;
          starve_d = '0;
        end else if (starved) begin
          starve_d = starve_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: FIFO write port and ready are driven only for the owner in XFER
  always_comb begin
    req_ready  = '0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    busy       = 1'b0;
    timeout    = 1'b0;
    grant_id   = grant_q;
    if (state_q == S_XFER) begin
      busy       = 1'b1;
      fifo_wr    = cur_valid && !fifo_full;
      fifo_wdata = cur_data;
      timeout    = expire;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_q == GW'(i)) req_ready[i] = !fifo_full;
      end
    end
  end

endmodule

// File: tb/tb_ef_uart_tx_arbiter.sv
// Directed bench for ef_uart_tx_arbiter with a cycle-level reference model
// and per-test literal expectations on the observed write/grant streams.
`timescale 1ns/1ps
module tb_ef_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_full = 1'b0;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [NR*W-1:0] req_data;
  logic          fifo_wr;
  logic [W-1:0]  fifo_wdata;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout;

  ef_uart_tx_arbiter #(.NUM_REQ(NR), .DW(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- requester sources ----------------
  logic [8:0] qmem [NR][64];
  int qwr [NR];
  int qrd [NR];

  function automatic void refresh();
    for (int i = 0; i < NR; i++) begin
      if (qrd[i] < qwr[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = qmem[i][qrd[i]][7:0];
        req_last[i]        = qmem[i][qrd[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qmem[r][qwr[r]] = {l, d};
    qwr[r]++;
    refresh();
  endtask

  function automatic void flush();
    for (int i = 0; i < NR; i++) begin
      qwr[i] = 0;
      qrd[i] = 0;
    end
    refresh();
  endfunction

  initial begin
    logic [NR-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) qrd[i]++;
      refresh();
    end
  end

  // ---------------- reference model + logs ----------------
  int m_owner = -1;
  int m_rr = 0;
  int m_starve = 0;
  int m_grant = 0;
  int cyc = 0;
  int wcnt = 0, gcnt = 0, tcnt = 0, stall_viol = 0;
  logic [7:0] wdat [64];
  int wcyc [64];
  int gid  [16];
  int tcyc [8];
  logic prev_busy = 1'b0;

  function automatic int pick(input logic [NR-1:0] v, input int rr);
    int best = -1;
    int bd = NR;
    for (int i = 0; i < NR; i++) begin
      if (v[i] && ((i - rr + NR) % NR) < bd) begin
        bd = (i - rr + NR) % NR;
        best = i;
      end
    end
`ifdef EF_UART_TX_ARB_PRIO_EN
    if (v[0]) best = 0;
`endif
    return best;
  endfunction

  function automatic int next_rr(input int g, input int rr);
`ifdef EF_UART_TX_ARB_PRIO_EN
    if (g == 0) return rr;
`endif
    return (g + 1) % NR;
  endfunction

  initial begin
    logic [16:0] exp_v, act_v;
    logic e_busy, e_to, e_wr;
    logic [3:0] e_ready;
    logic [7:0] e_wdata;
    int g;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_owner = -1; m_rr = 0; m_starve = 0; m_grant = 0;
      end
      e_busy = 1'b0; e_to = 1'b0; e_wr = 1'b0; e_ready = '0; e_wdata = '0;
      g = m_owner;
      if (m_owner >= 0) begin
        e_busy  = 1'b1;
        e_ready = fifo_full ? 4'b0 : 4'(1 << g);
        e_wr    = req_valid[g] && !fifo_full;
        e_wdata = req_data[g*W +: W];
        e_to    = !req_valid[g] && (m_starve == TO - 1);
      end
      exp_v = {e_busy, e_to, e_wr, 2'(m_grant), e_ready, e_wdata};
      act_v = {busy, timeout, fifo_wr, grant_id, req_ready, fifo_wdata};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle_model cyc=%0d {busy,to,wr,gid,ready,wdata} got=%h want=%h",
                 cyc, act_v, exp_v);
      end
      if (fifo_wr && wcnt < 64) begin wdat[wcnt] = fifo_wdata; wcyc[wcnt] = cyc; wcnt++; end
      if (busy && !prev_busy && gcnt < 16) begin gid[gcnt] = int'(grant_id); gcnt++; end
      prev_busy = busy;
      if (timeout && tcnt < 8) begin tcyc[tcnt] = cyc; tcnt++; end
      if (fifo_full && (fifo_wr || (|req_ready))) stall_viol++;
      if (rst_n) begin
        if (m_owner < 0) begin
          if (en && (|req_valid)) begin
            m_owner = pick(req_valid, m_rr); m_grant = m_owner; m_starve = 0;
          end
        end else if (e_wr) begin
          m_starve = 0;
          if (req_last[g]) begin m_owner = -1; m_rr = next_rr(g, m_rr); end
        end else if (!req_valid[g]) begin
          if (e_to) begin m_owner = -1; m_rr = next_rr(g, m_rr); m_starve = 0; end
          else m_starve++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int cnt_of(input int which);
    return (which == 0) ? wcnt : gcnt;
  endfunction

  task automatic wait_for(input string nm, input int which, input int n, input int budget);
    int k = 0;
    while (cnt_of(which) < n && k < budget) begin step(); k++; end
    check({nm, "_wait"}, (cnt_of(which) >= n) ? 1 : 0, 1);
  endtask

  task automatic do_reset(input logic en_v);
    rst_n = 1'b0;
    fifo_full = 1'b0;
    flush();
    step();
    step();
    wcnt = 0; gcnt = 0; tcnt = 0; stall_viol = 0;
    en = en_v;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_w [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
    logic [7:0] exp_b [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    refresh();

    // Enable low blocks arbitration; then fairness with 2-byte packets
    do_reset(1'b0);
    for (int i = 0; i < NR; i++)
      for (int p = 0; p < 2; p++) begin
        push(i, 8'(i*16 + p*2 + 1), 1'b0);
        push(i, 8'(i*16 + p*2 + 2), 1'b1);
      end
    repeat (5) step();
    check("en_low_no_grant", gcnt, 0);
    check("en_low_busy", int'(busy), 0);
    en = 1'b1;
    wait_for("fair", 0, 16, 120);
    for (int i = 0; i < 5; i++) check($sformatf("fair_grant%0d", i), gid[i], exp_g[i]);
    for (int i = 0; i < 10; i++) check($sformatf("fair_byte%0d", i), int'(wdat[i]), int'(exp_w[i]));
    check("fair_in_packet_gap", wcyc[1] - wcyc[0], 1);
    check("fair_between_packet_gap", wcyc[2] - wcyc[1], 2);

    // Packet lock: req1 holds the grant over a continuously valid req2
    do_reset(1'b1);
    push(1, 8'hC3, 1'b0);
    push(1, 8'h91, 1'b1);
    push(2, 8'h55, 1'b1);
    wait_for("lock", 0, 3, 40);
    check("lock_b0", int'(wdat[0]), 'hC3);
    check("lock_b1", int'(wdat[1]), 'h91);
    check("lock_b2", int'(wdat[2]), 'h55);
    check("lock_g0", gid[0], 1);
    check("lock_g1", gid[1], 2);
    check("lock_contig", wcyc[1] - wcyc[0], 1);

    // Backpressure: five full cycles mid-packet
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push(0, exp_b[i], (i == 3) ? 1'b1 : 1'b0);
    wait_for("bp_first", 0, 1, 20);
    fifo_full = 1'b1;
    repeat (5) step();
    fifo_full = 1'b0;
    wait_for("bp_all", 0, 4, 20);
    for (int i = 0; i < 4; i++) check($sformatf("bp_byte%0d", i), int'(wdat[i]), int'(exp_b[i]));
    check("bp_stall_span", wcyc[1] - wcyc[0], 6);
    check("bp_resume_rate", wcyc[3] - wcyc[1], 2);
    check("bp_no_timeout", tcnt, 0);
    check("bp_outputs_quiet", stall_viol, 0);

    // Timeout: req2 sends one non-last byte and goes silent
    do_reset(1'b1);
    push(2, 8'hA5, 1'b0);
    push(3, 8'h77, 1'b1);
    wait_for("to", 0, 2, 60);
    check("to_g0", gid[0], 2);
    check("to_g1", gid[1], 3);
    check("to_count", tcnt, 1);
    check("to_delay", tcyc[0] - wcyc[0], 16);
    check("to_next_byte", int'(wdat[1]), 'h77);
    check("to_regrant_gap", wcyc[1] - tcyc[0], 2);

    // Reset mid-packet, then arbitration restarts from index 0
    do_reset(1'b1);
    push(2, 8'h5A, 1'b1);
    wait_for("rst_pre", 0, 1, 20);
    for (int i = 0; i < 4; i++) push(1, 8'(i + 1), (i == 3) ? 1'b1 : 1'b0);
    wait_for("rst_mid", 0, 3, 20);
    check("rst_pre_grant", gid[1], 1);
    check("rst_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_wr", int'(fifo_wr), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_timeout", int'(timeout), 0);
    do_reset(1'b1);
    push(1, 8'hAA, 1'b1);
    push(3, 8'hBB, 1'b1);
    wait_for("rst_post", 0, 2, 30);
    check("rst_post_g0", gid[0], 1);
    check("rst_post_g1", gid[1], 3);
    check("rst_post_b0", int'(wdat[0]), 'hAA);

    // rr_ptr=2 with req0 and req2 contending
    do_reset(1'b1);
    push(1, 8'h66, 1'b1);
    wait_for("prio_pre", 0, 1, 20);
    push(0, 8'hE0, 1'b1);
    push(2, 8'hE2, 1'b1);
    wait_for("prio", 0, 3, 30);
`ifdef EF_UART_TX_ARB_PRIO_EN
    check("prio_winner", gid[1], 0);
    check("prio_byte", int'(wdat[1]), 'hE0);
`else
    check("rr_winner", gid[1], 2);
    check("rr_byte", int'(wdat[1]), 'hE2);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
